// File: rtl/mul_pkg.sv
// Shared types and default widths for the multiplier issue/writeback wrapper.
package mul_pkg;

  localparam int unsigned MulWidth = 32;
  localparam int unsigned MulTagW  = 5;

  typedef struct packed {
    logic               valid;
    logic               is_signed;
    logic               hi;
    logic [MulTagW-1:0] dest;
  } mul_tag_t;

  typedef struct packed {
    logic [MulTagW-1:0]  dest;
    logic [MulWidth-1:0] data;
  } wb_entry_t;

  function automatic logic [MulWidth-1:0] sel_half(logic [2*MulWidth-1:0] prod, logic hi);
    return hi ? prod[2*MulWidth-1:MulWidth] : prod[MulWidth-1:0];
  endfunction

endpackage

// File: rtl/mul_issue_wb_if.sv
// Issue and writeback handshake bundle for mul_issue_wb.
interface mul_issue_wb_if
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = MulWidth,
  parameter int unsigned TAG_W = MulTagW
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic             in_hi;
  logic [TAG_W-1:0] in_dest;
  logic [WIDTH-1:0] in_op1;
  logic [WIDTH-1:0] in_op2;

  logic             wb_valid;
  logic             wb_ready;
  logic [TAG_W-1:0] wb_dest;
  logic [WIDTH-1:0] wb_data;

  modport master (
    output in_valid, in_signed, in_hi, in_dest, in_op1, in_op2, wb_ready,
    input  in_ready, wb_valid, wb_dest, wb_data
  );

  modport slave (
    input  in_valid, in_signed, in_hi, in_dest, in_op1, in_op2, wb_ready,
    output in_ready, wb_valid, wb_dest, wb_data
  );

endinterface

// File: rtl/mul_pipe.sv
// Fixed-latency pipelined multiplier; signedness is applied at the output stage, so is_signed_i
// belongs to the op leaving the pipe. Data registers are intentionally not reset.
module mul_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned PIPE_DEPTH = 3
) (
  input  logic                 clk_i,
  input  logic [WIDTH-1:0]     op1_i,
  input  logic [WIDTH-1:0]     op2_i,
  input  logic                 is_signed_i,
  output logic [2*WIDTH-1:0]   res_o
);

  logic [WIDTH-1:0] a_q [PIPE_DEPTH];
  logic [WIDTH-1:0] b_q [PIPE_DEPTH];
  logic [WIDTH-1:0] a_d [PIPE_DEPTH];
  logic [WIDTH-1:0] b_d [PIPE_DEPTH];

  always_comb begin
    a_d[0] = op1_i;
    b_d[0] = op2_i;
    for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
  end

  always_ff @(posedge clk_i) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  logic [WIDTH-1:0]   a_tail, b_tail;
  logic [2*WIDTH-1:0] a_ext, b_ext;

  assign a_tail = a_q[PIPE_DEPTH-1];
  assign b_tail = b_q[PIPE_DEPTH-1];

  // Sign- or zero-extend to full product width; the truncated product is then exact.
  always_comb begin
    a_ext = {{WIDTH{is_signed_i & a_tail[WIDTH-1]}}, a_tail};
    b_ext = {{WIDTH{is_signed_i & b_tail[WIDTH-1]}}, b_tail};
    res_o = a_ext * b_ext;
  end

endmodule

// File: rtl/mul_wb_fifo.sv
// Synchronous FIFO of writeback entries; any depth >= 2, pointers wrap modulo DEPTH.
module mul_wb_fifo
  import mul_pkg::*;
#(
  parameter int unsigned DEPTH = 5,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            push_i,
  input  wb_entry_t       push_data_i,
  input  logic            pop_i,
  output wb_entry_t       head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);

  wb_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] wrap_inc(logic [PtrW-1:0] p);
    return (p == LastIdx) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == DepthC);
  assign count_o = cnt_q;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  assign do_pop  = pop_i & ~empty_o;
  // Push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wrap_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = wrap_inc(rd_ptr_q);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_o && !pop_i))
    else $error("mul_wb_fifo: push while full");

endmodule

// File: rtl/mul_issue_wb.sv
// Valid/ready wrapper around a fixed-latency multiplier: shadow tag pipe, result half select and
// a credit-limited writeback FIFO (the multiplier itself cannot stall).
module mul_issue_wb
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH      = MulWidth,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned FIFO_DEPTH = 5,
  parameter int unsigned TAG_W      = MulTagW
) (
  input  logic               clk,
  input  logic               reset,
  mul_issue_wb_if.slave      bus,
  output logic [WIDTH-1:0]   mul_op1,
  output logic [WIDTH-1:0]   mul_op2,
  output logic               mul_is_signed,
  input  logic [2*WIDTH-1:0] mul_res,
  output logic               busy
);

  localparam int unsigned CntW   = $clog2(PIPE_DEPTH + FIFO_DEPTH + 1);
  localparam int unsigned FCntW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] FifoDepthC = CntW'(FIFO_DEPTH);

  if (FIFO_DEPTH < PIPE_DEPTH + 2) begin : g_bad_fifo_depth
    $error("mul_issue_wb: FIFO_DEPTH must be >= PIPE_DEPTH + 2");
  end
  if (PIPE_DEPTH < 1) begin : g_bad_pipe_depth
    $error("mul_issue_wb: PIPE_DEPTH must be >= 1");
  end
  if (WIDTH != MulWidth || TAG_W != MulTagW) begin : g_bad_widths
    $error("mul_issue_wb: WIDTH/TAG_W must match mul_pkg entry types");
  end

  mul_tag_t         stage_q [PIPE_DEPTH];
  mul_tag_t         stage_d [PIPE_DEPTH];
  mul_tag_t         tail;
  logic             in_ready, accept;
  logic [CntW-1:0]  credit;
  logic [FCntW-1:0] fifo_cnt;
  logic             fifo_full, fifo_empty;
  wb_entry_t        push_entry, head;

  // Credits come only from registered state so wb_ready never reaches in_ready.
  always_comb begin
    credit = CntW'(fifo_cnt);
    for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
      credit = credit + CntW'(stage_q[k].valid);
    end
  end

  assign in_ready     = (credit < FifoDepthC);
  assign accept       = bus.in_valid & in_ready;
  assign bus.in_ready = in_ready;
  assign busy         = (credit != '0);

  assign mul_op1 = accept ? bus.in_op1 : '0;
  assign mul_op2 = accept ? bus.in_op2 : '0;

  always_comb begin
    stage_d[0].valid     = accept;
    stage_d[0].is_signed = bus.in_signed;
    stage_d[0].hi        = bus.in_hi;
    stage_d[0].dest      = bus.in_dest;
    for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tail          = stage_q[PIPE_DEPTH-1];
  assign mul_is_signed = tail.valid & tail.is_signed;

  always_comb begin
    push_entry.dest = tail.dest;
    push_entry.data = sel_half(mul_res, tail.hi);
  end

  mul_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (tail.valid),
    .push_data_i (push_entry),
    .pop_i       (bus.wb_ready),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt)
  );

  assign bus.wb_valid = ~fifo_empty;
  assign bus.wb_dest  = head.dest;
  assign bus.wb_data  = head.data;

  // Credits guarantee this never fires; kept as a guard on the credit arithmetic.
  assert property (@(posedge clk) disable iff (reset) !(tail.valid && fifo_full && !bus.wb_ready))
    else $error("mul_issue_wb: writeback overflow");

endmodule

// File: tb/tb_mul_issue_wb.sv
// Scoreboard bench for mul_issue_wb driving a behavioural pipelined multiplier.
module tb_mul_issue_wb;
  import mul_pkg::*;

  localparam int unsigned W  = 32;
  localparam int unsigned PD = 3;
  localparam int unsigned FD = 5;
  localparam int unsigned TW = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_issue_wb_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  logic [W-1:0]   mul_op1, mul_op2;
  logic           mul_is_signed;
  logic [2*W-1:0] mul_res;
  logic           busy;

  mul_issue_wb #(
    .WIDTH      (W),
    .PIPE_DEPTH (PD),
    .FIFO_DEPTH (FD),
    .TAG_W      (TW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .mul_op1       (mul_op1),
    .mul_op2       (mul_op2),
    .mul_is_signed (mul_is_signed),
    .mul_res       (mul_res),
    .busy          (busy)
  );

  mul_pipe #(
    .WIDTH      (W),
    .PIPE_DEPTH (PD)
  ) u_mul (
    .clk_i       (clk),
    .op1_i       (mul_op1),
    .op2_i       (mul_op2),
    .is_signed_i (mul_is_signed),
    .res_o       (mul_res)
  );

  typedef struct {
    logic [TW-1:0] dest;
    logic [W-1:0]  data;
  } exp_t;

  exp_t sb_q[$];
  int   pop_cyc[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  int   cyc      = 0;
  logic done_rand = 1'b0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_half(logic [W-1:0] a, logic [W-1:0] b, logic sgn,
                                            logic hi);
    logic [63:0] p;
    if (sgn) p = $unsigned(64'($signed(a)) * 64'($signed(b)));
    else     p = 64'(a) * 64'(b);
    return hi ? p[63:32] : p[31:0];
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accepted issue, pop and compare on writeback handshake.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back('{dest: bus.in_dest,
                         data: ref_half(bus.in_op1, bus.in_op2, bus.in_signed, bus.in_hi)});
        n_push++;
      end
      if (bus.wb_valid && bus.wb_ready) begin
        exp_t e;
        if (sb_q.size() == 0) begin
          check_eq("unexpected_wb", 64'(bus.wb_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_wb_dest", 64'(bus.wb_dest), 64'(e.dest));
          check_eq("sb_wb_data", 64'(bus.wb_data), 64'(e.data));
        end
        n_pop++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                       input logic hi, input logic [TW-1:0] d, output int waits);
    bus.in_op1    = a;
    bus.in_op2    = b;
    bus.in_signed = sgn;
    bus.in_hi     = hi;
    bus.in_dest   = d;
    bus.in_valid  = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      waits++;
      if (waits >= 200) begin
        check_eq("issue_timeout", 64'(bus.in_ready), 64'd1);
        break;
      end
      @(posedge clk);
      #1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_lat(input logic [W-1:0] d, input logic [TW-1:0] t);
    for (int k = 1; k <= int'(PD) + 1; k++) begin
      @(negedge clk);
      if (k <= int'(PD)) begin
        check_eq("lat_early_wb_valid", 64'(bus.wb_valid), 64'd0);
      end else begin
        check_eq("lat_wb_valid", 64'(bus.wb_valid), 64'd1);
        check_eq("lat_wb_data", 64'(bus.wb_data), 64'(d));
        check_eq("lat_wb_dest", 64'(bus.wb_dest), 64'(t));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb_q.size() != 0 || busy) && k < 300) begin
      @(negedge clk);
      k++;
    end
    check_eq("drain_busy", 64'(busy), 64'd0);
    check_eq("drain_sb_empty", 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w, stalls, base, gaps, acc, seen, push0, pop0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.in_hi     = 1'b0;
    bus.in_dest   = '0;
    bus.in_op1    = '0;
    bus.in_op2    = '0;
    bus.wb_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_wb_dest", 64'(bus.wb_dest), 64'd0);
    check_eq("rst_wb_data", 64'(bus.wb_data), 64'd0);
    @(posedge clk);
    #1;

    // Signed low half with latency, then both high-half cases.
    issue(32'hFFFF_FFFD, 32'd7, 1'b1, 1'b0, 5'd5, w);
    expect_lat(32'hFFFF_FFEB, 5'd5);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 5'd9, w);
    expect_lat(32'hFFFF_FFFE, 5'd9);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 5'd10, w);
    expect_lat(32'h0000_0000, 5'd10);
    wait_drain();

    // Back-to-back throughput.
    stalls = 0;
    base   = pop_cyc.size();
    for (int i = 0; i < 20; i++) begin
      issue($urandom, $urandom, 1'(i % 2), 1'($urandom_range(0, 1)), 5'(i), w);
      stalls += w;
    end
    wait_drain();
    check_eq("b2b_stalls", 64'(stalls), 64'd0);
    check_eq("b2b_pop_count", 64'(pop_cyc.size() - base), 64'd20);
    gaps = 0;
    for (int i = 1; i < 20 && base + i < pop_cyc.size(); i++) begin
      if (pop_cyc[base + i] - pop_cyc[base + i - 1] != 1) gaps++;
    end
    check_eq("b2b_pop_gaps", 64'(gaps), 64'd0);

    // Backpressure fills exactly FIFO_DEPTH credits.
    bus.wb_ready = 1'b0;
    acc = 0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.in_op1    = $urandom;
      bus.in_op2    = $urandom;
      bus.in_signed = 1'($urandom_range(0, 1));
      bus.in_hi     = 1'($urandom_range(0, 1));
      bus.in_dest   = 5'(16 + acc);
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check_eq("bp_accepted", 64'(acc), 64'(FD));
    @(negedge clk);
    check_eq("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    check_eq("bp_wb_valid", 64'(bus.wb_valid), 64'd1);
    @(posedge clk);
    #1 bus.wb_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_ready_pop_cycle", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check_eq("bp_ready_after_pop", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    wait_drain();

    // Reset with two ops in flight.
    issue(32'd3, 32'd4, 1'b0, 1'b0, 5'd1, w);
    issue(32'd5, 32'd6, 1'b0, 1'b0, 5'd2, w);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_mid_in_ready", 64'(bus.in_ready), 64'd1);
    check_eq("rst_mid_busy", 64'(busy), 64'd0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (bus.wb_valid) seen++;
      @(negedge clk);
    end
    check_eq("rst_mid_ghost_wb", 64'(seen), 64'd0);
    @(posedge clk);
    #1;

    // Random issue and random writeback backpressure.
    push0 = n_push;
    pop0  = n_pop;
    fork
      begin
        while (!done_rand) begin
          @(posedge clk);
          #1 bus.wb_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 1) == 1) begin
            @(posedge clk);
            #1;
          end
          issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'(i), w);
        end
        done_rand = 1'b1;
      end
    join
    bus.wb_ready = 1'b1;
    wait_drain();
    check_eq("rand_accepted", 64'(n_push - push0), 64'd1000);
    check_eq("rand_popped", 64'(n_pop - pop0), 64'd1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
